// File: rtl/arith_pipe_pkg.sv
// -----------------------------------------------------------------------------
// arith_pipe_pkg
//
// Shared definitions for the arith_pipe_vr pipeline:
//   - default operand/result width and tag width
//   - stage payload layout (data, d, tag) at the default widths
//   - sat_mul: multiply with wrap or saturation, returning the overflow flag
//
// sat_mul works on operands zero-extended to MAX_W bits and interprets
// only the low `w` bits of the result, so one function serves every
// WIDTH up to MAX_W.
// -----------------------------------------------------------------------------
package arith_pipe_pkg;

    localparam int DEFAULT_WIDTH = 10;
    localparam int DEFAULT_TAG_W = 4;

    // Widest operand sat_mul supports.
    localparam int MAX_W = 32;

    // Payload carried by a middle stage at the default widths.
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] data;
        logic [DEFAULT_WIDTH-1:0] d;
        logic [DEFAULT_TAG_W-1:0] tag;
    } stage_payload_t;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] value;
    } mul_result_t;

    // Full-precision product of x and y, reduced to w bits.
    // ovf is set when any product bit at or above w is set.
    // With sat set, an overflowing product is clamped to 2^w-1.
    function automatic mul_result_t sat_mul(
        input logic [MAX_W-1:0] x,
        input logic [MAX_W-1:0] y,
        input int unsigned      w,
        input logic             sat
    );
        logic [2*MAX_W-1:0] p;
        logic [2*MAX_W-1:0] mask;
        mul_result_t        r;
        p       = {{MAX_W{1'b0}}, x} * {{MAX_W{1'b0}}, y};
        mask    = ({{(2*MAX_W-1){1'b0}}, 1'b1} << w) - {{(2*MAX_W-1){1'b0}}, 1'b1};
        r.ovf   = |(p & ~mask);
        r.value = (sat && r.ovf) ? mask[MAX_W-1:0] : (p[MAX_W-1:0] & mask[MAX_W-1:0]);
        return r;
    endfunction

endpackage : arith_pipe_pkg

// File: rtl/pipe_stage_vr.sv
// -----------------------------------------------------------------------------
// pipe_stage_vr
//
// Generic valid/ready register slice. The slice is ready when it is empty
// or when its downstream takes the current contents this cycle, so an
// empty slice fills even while a later slice is stalled.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset (clears valid and payload)
//   up_valid_i  upstream holds valid data
//   up_data_i   upstream payload (PW bits)
//   dn_ready_i  downstream accepts this slice's contents this cycle
//   ready_o     this slice accepts upstream data this cycle
//   valid_o     this slice holds valid data
//   data_o      registered payload
// -----------------------------------------------------------------------------
module pipe_stage_vr #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid_i,
    input  logic [PW-1:0] up_data_i,
    input  logic          dn_ready_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [PW-1:0] data_o
);

    logic          valid_q;
    logic          valid_d;
    logic [PW-1:0] data_q;
    logic [PW-1:0] data_d;

    assign ready_o = ~valid_q | dn_ready_i;

    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = up_valid_i;
            // Payload only moves on a real transfer; a bubble keeps old data.
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs; the payload is cleared on reset as
    // well so the outputs read 0 after reset rather than stale data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : pipe_stage_vr

// File: rtl/arith_pipe_vr.sv
// -----------------------------------------------------------------------------
// arith_pipe_vr
//
// Three-stage flow-controlled pipeline computing
//     f = ((a+b) + (c-d)) * d
// over WIDTH-bit unsigned operands, with a pass-through tag and an
// overflow flag.
//   stage 1: x1 = a+b, x2 = c-d (both wrap), d, tag
//   stage 2: x3 = x1+x2 (wraps), d, tag
//   stage 3: f = low WIDTH bits of x3*d (or clamped), f_ovf, tag
//
// Build option: define ARITH_PIPE_SAT_EN to make stage 3 saturate f to
// 2^WIDTH-1 when the product overflows. Without it f wraps. f_ovf is the
// same in both builds; stages 1 and 2 always wrap.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand set a/b/c/d/in_tag is valid
//   in_ready   pipeline accepts the operand set this cycle
//   a,b,c,d    WIDTH-bit unsigned operands
//   in_tag     TAG_W-bit sideband returned with the result
//   out_valid  f/f_ovf/out_tag hold a valid result
//   out_ready  consumer takes the result this cycle
//   f          WIDTH-bit result
//   f_ovf      full product did not fit in WIDTH bits
//   out_tag    tag of the result
//   busy       at least one stage holds valid data
//
// WIDTH must be in 2..MAX_W (see arith_pipe_pkg), TAG_W >= 1.
// -----------------------------------------------------------------------------
module arith_pipe_vr
    import arith_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TAG_W = DEFAULT_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             f_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

`ifdef ARITH_PIPE_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] x1;
        logic [WIDTH-1:0] x2;
        logic [WIDTH-1:0] d;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] x3;
        logic [WIDTH-1:0] d;
        logic [TAG_W-1:0] tag;
    } s2_t;

    typedef struct packed {
        logic [WIDTH-1:0] f;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } s3_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;

    logic v1, v2, v3;
    logic r1, r2, r3;

    mul_result_t mul_res;

    // ---------------------------------------------------------------- stage 1
    always_comb begin
        s1_d.x1  = a + b;
        s1_d.x2  = c - d;
        s1_d.d   = d;
        s1_d.tag = in_tag;
    end

    pipe_stage_vr #(
        .PW($bits(s1_t))
    ) u_stage1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid_i (in_valid),
        .up_data_i  (s1_d),
        .dn_ready_i (r2),
        .ready_o    (r1),
        .valid_o    (v1),
        .data_o     (s1_q)
    );

    // ---------------------------------------------------------------- stage 2
    always_comb begin
        s2_d.x3  = s1_q.x1 + s1_q.x2;
        s2_d.d   = s1_q.d;
        s2_d.tag = s1_q.tag;
    end

    pipe_stage_vr #(
        .PW($bits(s2_t))
    ) u_stage2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid_i (v1),
        .up_data_i  (s2_d),
        .dn_ready_i (r3),
        .ready_o    (r2),
        .valid_o    (v2),
        .data_o     (s2_q)
    );

    // ---------------------------------------------------------------- stage 3
    always_comb begin
        mul_res  = sat_mul(MAX_W'(s2_q.x3), MAX_W'(s2_q.d), WIDTH, SAT_EN);
        s3_d.f   = mul_res.value[WIDTH-1:0];
        s3_d.ovf = mul_res.ovf;
        s3_d.tag = s2_q.tag;
    end

    // Bits of the shared-width result above WIDTH are always zero here.
    if (WIDTH < MAX_W) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^mul_res.value[MAX_W-1:WIDTH];
    end

    pipe_stage_vr #(
        .PW($bits(s3_t))
    ) u_stage3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid_i (v2),
        .up_data_i  (s3_d),
        .dn_ready_i (out_ready),
        .ready_o    (r3),
        .valid_o    (v3),
        .data_o     (s3_q)
    );

    // ---------------------------------------------------------------- outputs
    // out_ready ripples back to in_ready through r3/r2/r1 so a full
    // pipeline can accept and emit in the same cycle.
    assign in_ready  = r1;
    assign out_valid = v3;
    assign f         = s3_q.f;
    assign f_ovf     = s3_q.ovf;
    assign out_tag   = s3_q.tag;
    assign busy      = v1 | v2 | v3;

endmodule : arith_pipe_vr

// File: tb/tb_arith_pipe_vr.sv
// -----------------------------------------------------------------------------
// tb_arith_pipe_vr
//
// Self-checking bench for arith_pipe_vr at WIDTH=10, TAG_W=4. Inputs are
// driven on the falling edge; outputs are sampled 1 time unit later.
// Honours ARITH_PIPE_SAT_EN for the expected value of overflowing results.
// -----------------------------------------------------------------------------
module tb_arith_pipe_vr;

    localparam int W = 10;
    localparam int T = 4;

`ifdef ARITH_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b, c, d;
    logic [T-1:0] in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] f;
    logic         f_ovf;
    logic [T-1:0] out_tag;
    logic         busy;

    always #5 clk = ~clk;

    arith_pipe_vr #(
        .WIDTH(W),
        .TAG_W(T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .f_ovf     (f_ovf),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] a, b, c, d;
        logic [T-1:0] tag;
        logic [W-1:0] f_wrap;
        logic [W-1:0] f_sat;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] f;
        logic         ovf;
        logic [T-1:0] tag;
    } exp_t;

    vec_t vecs[10];

    // Reference calculation for the random streaming section.
    function automatic exp_t model(input logic [W-1:0] ma, mb, mc, md, input logic [T-1:0] mt);
        logic [W-1:0]   x1, x2, x3;
        logic [2*W-1:0] p;
        exp_t           e;
        x1    = ma + mb;
        x2    = mc - md;
        x3    = x1 + x2;
        p     = {{W{1'b0}}, x3} * {{W{1'b0}}, md};
        e.ovf = |p[2*W-1:W];
        e.f   = (SAT && e.ovf) ? {W{1'b1}} : p[W-1:0];
        e.tag = mt;
        return e;
    endfunction

    task automatic drive(input logic [W-1:0] ta, tb, tc, td, input logic [T-1:0] tt);
        a      = ta;
        b      = tb;
        c      = tc;
        d      = td;
        in_tag = tt;
    endtask

    // One set through an otherwise empty, unstalled pipe: exact 3-cycle latency.
    task automatic run_single(input vec_t v, input string nm);
        @(negedge clk);
        drive(v.a, v.b, v.c, v.d, v.tag);
        in_valid = 1'b1;
        #1 check({nm, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({nm, "_lat1"}, out_valid, 0);
        @(negedge clk);
        #1 check({nm, "_lat2"}, out_valid, 0);
        @(negedge clk);
        #1;
        check({nm, "_valid"}, out_valid, 1);
        check({nm, "_f"}, f, SAT ? v.f_sat : v.f_wrap);
        check({nm, "_ovf"}, f_ovf, v.ovf);
        check({nm, "_tag"}, out_tag, v.tag);
    endtask

    initial begin
        exp_t         sb[$];
        exp_t         e;
        exp_t         held;
        logic         hold_pending;
        int           sent, got, cycles;

        //            a     b     c     d    tag  f_wrap f_sat ovf
        vecs[0] = '{  3,    4,    9,    2,   5,   28,    28,   0};
        vecs[1] = '{  0,    0,    1,    3,   6,   1018,  1023, 1};
        vecs[2] = '{  1,    2,    3,    0,   1,   0,     0,    0};
        vecs[3] = '{  1023, 2,    10,   4,   3,   28,    28,   0};
        vecs[4] = '{  100,  200,  50,   3,   9,   17,    1023, 1};
        vecs[5] = '{  10,   10,   100,  10,  12,  76,    1023, 1};
        vecs[6] = '{  31,   1,    0,    1,   7,   31,    31,   0};
        vecs[7] = '{  500,  500,  1000, 1,   2,   975,   975,  0};
        vecs[8] = '{  1023, 1023, 1023, 1023, 14, 2,     1023, 1};
        vecs[9] = '{  0,    0,    0,    0,   15,  0,     0,    0};

        // ---------------------------------------------------------- reset
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_f", f, 0);
        check("rst_f_ovf", f_ovf, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // ---------------------------------------------------------- vectors
        for (int i = 0; i < 10; i++) begin
            run_single(vecs[i], $sformatf("vec%0d", i));
        end

        // ---------------------------------------------------------- back-pressure
        // Operands (t,0,0,1) give f = t-1 without overflow.
        @(negedge clk);
        out_ready = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            if (t > 1) @(negedge clk);
            drive(W'(t), 0, 0, 1, T'(t));
            in_valid = 1'b1;
            #1 check($sformatf("bp_accept%0d_ready", t), in_ready, 1);
        end
        @(negedge clk);
        drive(4, 0, 0, 1, 4);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check($sformatf("bp_full_in_ready%0d", k), in_ready, 0);
            check($sformatf("bp_hold_valid%0d", k), out_valid, 1);
            check($sformatf("bp_hold_tag%0d", k), out_tag, 1);
            check($sformatf("bp_hold_f%0d", k), f, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 check("bp_ready_same_cycle", in_ready, 1);
        for (int t = 2; t <= 4; t++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check($sformatf("bp_order_valid%0d", t), out_valid, 1);
            check($sformatf("bp_order_tag%0d", t), out_tag, t);
            check($sformatf("bp_order_f%0d", t), f, t - 1);
        end
        @(negedge clk);
        #1;
        check("bp_drained_valid", out_valid, 0);
        check("bp_drained_busy", busy, 0);

        // ---------------------------------------------------------- bubble collapse
        out_ready = 1'b0;
        drive(3, 4, 9, 2, 7);
        in_valid = 1'b1;
        #1 check("bub_first_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("bub_busy1", busy, 1);
        @(negedge clk);
        #1 check("bub_busy2", busy, 1);
        @(negedge clk);
        #1;
        check("bub_in_s3", out_valid, 1);
        check("bub_busy3", busy, 1);
        @(negedge clk);
        drive(1, 2, 3, 0, 8);
        in_valid = 1'b1;
        #1;
        check("bub_second_ready", in_ready, 1);
        check("bub_busy4", busy, 1);
        @(negedge clk);
        drive(31, 1, 0, 1, 9);
        #1;
        check("bub_third_ready", in_ready, 1);
        check("bub_busy5", busy, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bub_full", in_ready, 0);
        check("bub_head_tag", out_tag, 7);
        check("bub_head_f", f, 28);
        out_ready = 1'b1;
        for (int t = 8; t <= 9; t++) begin
            @(negedge clk);
            #1;
            check($sformatf("bub_drain_valid%0d", t), out_valid, 1);
            check($sformatf("bub_drain_tag%0d", t), out_tag, t);
        end
        check("bub_drain_f9", f, 31);
        @(negedge clk);
        #1 check("bub_empty", busy, 0);

        // ---------------------------------------------------------- reset mid-flight
        drive(vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].d, vecs[0].tag);
        in_valid = 1'b1;
        @(negedge clk);
        drive(vecs[1].a, vecs[1].b, vecs[1].c, vecs[1].d, vecs[1].tag);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_f", f, 0);
        check("mid_rst_tag", out_tag, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 check($sformatf("mid_rst_no_stale%0d", k), out_valid, 0);
        end
        run_single(vecs[4], "post_rst");

        // ---------------------------------------------------------- streaming
        sent         = 0;
        got          = 0;
        cycles       = 0;
        hold_pending = 1'b0;
        held         = '{default: '0};
        while ((sent < 16 || got < 16) && cycles < 2000) begin
            @(negedge clk);
            if (hold_pending) begin
                check("stream_stall_valid", out_valid, 1);
                check("stream_stall_f", f, held.f);
                check("stream_stall_ovf", f_ovf, held.ovf);
                check("stream_stall_tag", out_tag, held.tag);
            end
            in_valid  = (sent < 16) ? ($urandom_range(0, 3) != 0) : 1'b0;
            drive(W'($urandom_range(0, 1023)), W'($urandom_range(0, 1023)),
                  W'($urandom_range(0, 1023)), W'($urandom_range(0, 1023)),
                  T'(sent));
            out_ready = (sent >= 16) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b, c, d, in_tag));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("stream_unexpected_result", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("stream%0d_f", got), f, e.f);
                    check($sformatf("stream%0d_ovf", got), f_ovf, e.ovf);
                    check($sformatf("stream%0d_tag", got), out_tag, e.tag);
                    got++;
                end
            end
            hold_pending = out_valid && !out_ready;
            held         = '{f: f, ovf: f_ovf, tag: out_tag};
            cycles++;
        end
        check("stream_results_received", got, 16);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("stream_final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_arith_pipe_vr
